// File: rtl/cache_way_ctrl_if.sv
// Bundles the request, response, refill and LRU-buffer signals of cache_way_ctrl.
// The controller connects through the slave modport; its environment uses master.
interface cache_way_ctrl_if #(
  parameter int ADDR_W = 27,
  parameter int SET_W  = 7
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_hit;
  logic [2:0]        resp_way;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_ack;
  logic [7:0]        o_hit_way_8;
  logic              o_hit_sig;
  logic              o_lru_write_enable;
  logic [SET_W-1:0]  o_addr_7;
  logic [7:0]        i_lru_flag;

  modport slave (
    input  req_valid, req_addr, resp_ready, mem_req_ready, mem_ack, i_lru_flag,
    output req_ready, resp_valid, resp_hit, resp_way, mem_req_valid, mem_req_addr,
           o_hit_way_8, o_hit_sig, o_lru_write_enable, o_addr_7
  );

  modport master (
    output req_valid, req_addr, resp_ready, mem_req_ready, mem_ack, i_lru_flag,
    input  req_ready, resp_valid, resp_hit, resp_way, mem_req_valid, mem_req_addr,
           o_hit_way_8, o_hit_sig, o_lru_write_enable, o_addr_7
  );
endinterface

// File: rtl/cache_way_ctrl.sv
// Request-side controller of the 8-way, 128-set cache: tag/valid storage, hit/miss
// resolution, victim selection, refill handshake and LRU buffer update.
//
// state       | meaning
// S_IDLE      | ready for a request; latch address on req_valid
// S_LOOKUP    | compare tags, pick hit way or victim
// S_REFILL_REQ| refill request to memory held until mem_req_ready
// S_REFILL_WAIT| wait for mem_ack, then write tag and valid
// S_UPDATE    | one-cycle LRU buffer strobe
// S_RESP      | response held until resp_ready
module cache_way_ctrl #(
  parameter int TAG_W  = 20,
  parameter int SET_W  = 7,
  parameter int ADDR_W = TAG_W + SET_W
) (
  input logic             clk,
  input logic             rst,
  cache_way_ctrl_if.slave bus
);
  localparam int SETS = 1 << SET_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_UPDATE, S_REFILL_REQ, S_REFILL_WAIT, S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        way_q, way_d;
  logic              hit_q, hit_d;
  logic              inv_q, inv_d;
  logic              fill_we;

  logic [TAG_W-1:0]  tag_q [8][SETS];
  logic [7:0]        valid_q [SETS];

  logic [SET_W-1:0]  set_idx;
  logic [TAG_W-1:0]  tag_lat;
  logic [7:0]        hit_vec;
  logic [7:0]        inv_vec;

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign set_idx = addr_q[SET_W-1:0];
  assign tag_lat = addr_q[ADDR_W-1:SET_W];

  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < 8; w++) begin
      hit_vec[w] = valid_q[set_idx][w] && (tag_q[w][set_idx] == tag_lat);
    end
    inv_vec = ~valid_q[set_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      way_q   <= '0;
      hit_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      way_q   <= way_d;
      hit_q   <= hit_d;
      inv_q   <= inv_d;
    end
  end

  // Tags need no reset: a way is only ever trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_we) tag_q[way_q][set_idx] <= tag_lat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (fill_we) begin
      valid_q[set_idx][way_q] <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    way_d   = way_q;
    hit_d   = hit_q;
    inv_d   = inv_q;
    fill_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (|hit_vec) begin
          way_d   = lowest_set(hit_vec);
          hit_d   = 1'b1;
          inv_d   = 1'b0;
          state_d = S_UPDATE;
        end else begin
          hit_d   = 1'b0;
          inv_d   = |inv_vec;
          // An empty LRU flag falls through to way 0 via lowest_set.
          way_d   = (|inv_vec) ? lowest_set(inv_vec) : lowest_set(bus.i_lru_flag);
          state_d = S_REFILL_REQ;
        end
      end
      S_REFILL_REQ: begin
        if (bus.mem_req_ready) state_d = S_REFILL_WAIT;
      end
      S_REFILL_WAIT: begin
        if (bus.mem_ack) begin
          fill_we = 1'b1;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: state_d = S_RESP;
      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready          = (state_q == S_IDLE);
    bus.mem_req_valid      = 1'b0;
    bus.mem_req_addr       = '0;
    bus.o_lru_write_enable = 1'b0;
    bus.o_hit_way_8        = '0;
    bus.o_hit_sig          = 1'b0;
    bus.resp_valid         = 1'b0;
    bus.resp_hit           = 1'b0;
    bus.resp_way           = '0;
    bus.o_addr_7           = set_idx;
    case (state_q)
      S_REFILL_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = addr_q;
      end
      S_UPDATE: begin
        bus.o_lru_write_enable = 1'b1;
        bus.o_hit_way_8        = 8'b1 << way_q;
        bus.o_hit_sig          = hit_q | inv_q;
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_hit   = hit_q;
        bus.resp_way   = way_q;
      end
      default: ;
    endcase
  end
endmodule
